prog_loader_master: RTL and testbench

- Master-side driver for the processor's serial program-load and run interface, sharing the processor clock.
- Accepts (address, instruction) words over a valid/ready handshake.
- Serializes each word as one 12-bit frame on csi_n/mosi, timed to the processor's IDLE→RECV→WRITE sequence.
- Drives proc_en to start and stop execution.
- Sits in the FPGA/harness wrapper or on-chip test logic, facing uio_in[3:0] of the processor.

---
 rtl/prog_loader_master.sv | 148 ++++++++++++++
 tb/tb_prog_loader_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader_master.sv
// Serial program-load master: shifts (addr, data) words LSB first into the processor loader and drives proc_en.
// Optional macro PROG_LOADER_CNT_EN adds frames_sent_out, a saturating count of completed frames.
module prog_loader_master #(
  parameter int FRAME_W    = 12,
  parameter int GAP_CYCLES = 1   // legal range 1..7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] frame_data_in,
  input  logic [3:0] frame_addr_in,
  input  logic       frame_valid_in,
  output logic       frame_ready_out,
  input  logic       run_req_in,
  output logic       csi_n_out,
  output logic       csd_n_out,
  output logic       mosi_out,
  output logic       proc_en_out,
  output logic       busy_out,
`ifdef PROG_LOADER_CNT_EN
  output logic [4:0] frames_sent_out,
`endif
  output logic [2:0] state_dbg
);

  // Handshake: a frame transfers on a rising clk edge where frame_valid_in and
  // frame_ready_out are both high; the source may change the word after that edge.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_SHIFT = 3'd2,
    S_GAP   = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);
  localparam logic [2:0] LAST_GAP = 3'(GAP_CYCLES - 1);

  state_t               state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [2:0]           gap_cnt_q, gap_cnt_d;
  logic [FRAME_W-1:0]   word_q;
  logic                 csi_n_d, mosi_d, ready_d, proc_en_d, busy_d;
  logic                 accept, gap_last, decide;

  assign accept   = frame_valid_in & frame_ready_out;
  assign gap_last = (state_q == S_GAP) && (gap_cnt_q == LAST_GAP);
  // The last gap cycle doubles as the idle decision slot so back-to-back frames cost 1+12+GAP cycles.
  assign decide   = (state_q == S_IDLE) || gap_last;

  assign csd_n_out = 1'b1;
  assign state_dbg = state_q;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      bit_cnt_q       <= '0;
      gap_cnt_q       <= '0;
      word_q          <= '0;
      csi_n_out       <= 1'b1;
      mosi_out        <= 1'b0;
      frame_ready_out <= 1'b0;
      proc_en_out     <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      gap_cnt_q       <= gap_cnt_d;
      if (accept) word_q <= {frame_data_in, frame_addr_in};
      csi_n_out       <= csi_n_d;
      mosi_out        <= mosi_d;
      frame_ready_out <= ready_d;
      proc_en_out     <= proc_en_d;
      busy_out        <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_SEL: begin
        state_d   = S_SHIFT;
        bit_cnt_d = '0;
      end
      S_SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      S_GAP:   gap_cnt_d = gap_cnt_q + 3'd1;
      S_RUN:   if (!run_req_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (decide) begin
      if (accept)
        state_d = S_SEL;
      else if (run_req_in && !frame_valid_in)
        state_d = S_RUN;
      else
        state_d = S_IDLE;
    end
  end

  // Output decode from the next state, so every output is a flop
  always_comb begin
    csi_n_d   = 1'b1;
    mosi_d    = 1'b0;
    ready_d   = 1'b0;
    proc_en_d = 1'b0;
    busy_d    = (state_d != S_IDLE);
    case (state_d)
      S_IDLE:  ready_d = 1'b1;
      S_SEL:   csi_n_d = 1'b0;
      S_SHIFT: begin
        // cs rises with the last bit; the receiver still clocks it in.
        csi_n_d = (bit_cnt_d == LAST_BIT);
        mosi_d  = word_q[bit_cnt_d];
      end
      S_GAP:   ready_d = (gap_cnt_d == LAST_GAP);
      S_RUN:   proc_en_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

`ifdef PROG_LOADER_CNT_EN
  logic [4:0] frames_sent_q;

  always_ff @(posedge clk) begin
    if (rst)
      frames_sent_q <= '0;
    else if (decide && (state_d == S_RUN))
      frames_sent_q <= '0;
    else if (gap_last && (frames_sent_q != 5'd31))
      frames_sent_q <= frames_sent_q + 5'd1;
  end

  assign frames_sent_out = frames_sent_q;
`endif

endmodule

// File: tb/tb_prog_loader_master.sv
// Directed bench for prog_loader_master with a small model of the processor's serial loader.
module tb_prog_loader_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] frame_data_in = '0;
  logic [3:0] frame_addr_in = '0;
  logic       frame_valid_in = 1'b0;
  logic       frame_ready_out;
  logic       run_req_in = 1'b0;
  logic       csi_n_out, csd_n_out, mosi_out, proc_en_out, busy_out;
  logic [2:0] state_dbg;
`ifdef PROG_LOADER_CNT_EN
  logic [4:0] frames_sent_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clk = ~clk;

  prog_loader_master dut (
    .clk             (clk),
    .rst             (rst),
    .frame_data_in   (frame_data_in),
    .frame_addr_in   (frame_addr_in),
    .frame_valid_in  (frame_valid_in),
    .frame_ready_out (frame_ready_out),
    .run_req_in      (run_req_in),
    .csi_n_out       (csi_n_out),
    .csd_n_out       (csd_n_out),
    .mosi_out        (mosi_out),
    .proc_en_out     (proc_en_out),
    .busy_out        (busy_out),
`ifdef PROG_LOADER_CNT_EN
    .frames_sent_out (frames_sent_out),
`endif
    .state_dbg       (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [4:0] exp);
`ifdef PROG_LOADER_CNT_EN
    check(tag, frames_sent_out, exp);
`endif
  endtask

  // processor loader model: IDLE -> RECV (12 shifts) -> WRITE
  logic [7:0]  icache [16];
  logic [11:0] rx_buf = '0;
  int          rx_st = 0;
  int          rx_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      rx_st  = 0;
      rx_cnt = 0;
    end else begin
      case (rx_st)
        0: if (!csi_n_out) begin rx_st = 1; rx_cnt = 0; end
        1: begin
          rx_buf = {mosi_out, rx_buf[11:1]};
          rx_cnt++;
          if (rx_cnt == 12) rx_st = 2;
        end
        default: begin
          icache[rx_buf[3:0]] = rx_buf[11:4];
          rx_st = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) check("excl_run_cs", {31'b0, proc_en_out & ~csi_n_out}, 32'd0);
  end

  // scoreboard
  logic [0:0] exp_q[$];
  int         mosi_tbl[12] = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1};
  logic       cs_hist[30];
  logic       busy_hist[30];

  initial begin
    int cs_low, nacc, hi, lo1, lo2;
    logic acc;
    logic [0:0] eb;
    for (int i = 0; i < 16; i++) icache[i] = 8'h00;

    // reset
    repeat (3) tick();
    check("rst_csi", csi_n_out, 1);
    check("rst_csd", csd_n_out, 1);
    check("rst_mosi", mosi_out, 0);
    check("rst_proc_en", proc_en_out, 0);
    check("rst_ready", frame_ready_out, 0);
    check("rst_busy", busy_out, 0);
    check_cnt("rst_cnt", 5'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", frame_ready_out, 1);
    check("post_rst_busy", busy_out, 0);

    // single frame addr 3 / data A5
    foreach (mosi_tbl[i]) exp_q.push_back(mosi_tbl[i][0]);
    frame_addr_in = 4'h3; frame_data_in = 8'hA5; frame_valid_in = 1'b1;
    tick();
    frame_valid_in = 1'b0;
    check("sel_csi", csi_n_out, 0);
    check("sel_mosi", mosi_out, 0);
    check("sel_ready", frame_ready_out, 0);
    check("sel_busy", busy_out, 1);
    cs_low = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      eb = exp_q.pop_front();
      check($sformatf("mosi_k%0d", k), mosi_out, eb);
      if (!csi_n_out) cs_low++;
    end
    check("cs_low_len", cs_low, 12);
    check("k11_csi", csi_n_out, 1);
    tick();
    check("gap_csi", csi_n_out, 1);
    check("gap_mosi", mosi_out, 0);
    check("gap_ready", frame_ready_out, 1);
    check("gap_csd", csd_n_out, 1);
    tick();
    check("idle_busy", busy_out, 0);
    check("idle_ready", frame_ready_out, 1);
    check("icache3", icache[3], 8'hA5);
    check_cnt("cnt_one", 5'd1);

    // back-to-back frames with valid held
    frame_addr_in = 4'h0; frame_data_in = 8'h12; frame_valid_in = 1'b1;
    nacc = 0;
    for (int c = 0; c < 29; c++) begin
      acc = frame_valid_in && frame_ready_out;
      tick();
      if (acc) begin
        nacc++;
        if (nacc == 1) begin frame_addr_in = 4'h1; frame_data_in = 8'h34; end
        else frame_valid_in = 1'b0;
      end
      cs_hist[c+1]   = csi_n_out;
      busy_hist[c+1] = busy_out;
    end
    lo1 = 0; hi = 0; lo2 = 0;
    for (int c = 1; c <= 12; c++)  if (!cs_hist[c]) lo1++;
    for (int c = 13; c <= 14; c++) if (cs_hist[c]) hi++;
    for (int c = 15; c <= 26; c++) if (!cs_hist[c]) lo2++;
    check("b2b_low1", lo1, 12);
    check("b2b_gap_hi", hi, 2);
    check("b2b_low2", lo2, 12);
    check("b2b_tail_hi", {31'b0, cs_hist[27] & cs_hist[28]}, 1);
    check("b2b_accepts", nacc, 2);
    check("b2b_busy28", busy_hist[28], 1);
    check("b2b_busy29", busy_hist[29], 0);
    check("icache0", icache[0], 8'h12);
    check("icache1", icache[1], 8'h34);
    check_cnt("cnt_three", 5'd3);

    // run requested together with a frame: frame first, then run
    run_req_in = 1'b1;
    frame_addr_in = 4'h5; frame_data_in = 8'h3C; frame_valid_in = 1'b1;
    tick();
    frame_valid_in = 1'b0;
    check("run_frame_sel", csi_n_out, 0);
    repeat (13) tick();
    check("run_gap_proc_en", proc_en_out, 0);
    check("run_gap_csi", csi_n_out, 1);
    tick();
    check("run_proc_en", proc_en_out, 1);
    check("run_ready", frame_ready_out, 0);
    check("run_busy", busy_out, 1);
    check("icache5", icache[5], 8'h3C);
    check_cnt("cnt_run_clr", 5'd0);
    frame_addr_in = 4'h7; frame_data_in = 8'h77; frame_valid_in = 1'b1;
    cs_low = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (!csi_n_out) cs_low++;
    end
    check("run_no_cs", cs_low, 0);
    check("run_held", proc_en_out, 1);

    // run falls with a frame already offered
    run_req_in = 1'b0;
    tick();
    check("stop_proc_en", proc_en_out, 0);
    check("stop_csi", csi_n_out, 1);
    check("stop_ready", frame_ready_out, 1);
    tick();
    frame_valid_in = 1'b0;
    check("stop_cs_fall", csi_n_out, 0);
    check("stop_proc_en2", proc_en_out, 0);
    repeat (14) tick();
    check("icache7", icache[7], 8'h77);
    check_cnt("cnt_after_run", 5'd1);

    // reset in the middle of a frame (k=5)
    frame_addr_in = 4'h9; frame_data_in = 8'hFF; frame_valid_in = 1'b1;
    tick();
    frame_valid_in = 1'b0;
    repeat (6) tick();
    check("mid_k5_mosi", mosi_out, 1);
    check("mid_k5_csi", csi_n_out, 0);
    rst = 1'b1;
    tick();
    check("mid_rst_csi", csi_n_out, 1);
    check("mid_rst_mosi", mosi_out, 0);
    check("mid_rst_ready", frame_ready_out, 0);
    check("mid_rst_busy", busy_out, 0);
    check_cnt("mid_rst_cnt", 5'd0);
    rst = 1'b0;
    tick();
    check("mid_post_ready", frame_ready_out, 1);
    check("mid_post_csi", csi_n_out, 1);
    repeat (3) tick();
    check("icache9", icache[9], 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
